// File: rtl/fetch_stage.sv
// Instruction fetch stage. Keeps at most one memory request in flight and feeds the IF/ID register.
// A one-entry skid buffer holds a word that arrives while decode stalls; flush discards any fetch in flight.
module fetch_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  output logic        o_pc_hold,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_ifid_valid,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] skid_word, skid_nxt;
  logic        ifid_valid_nxt;
  logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
  logic        pc_hold, req, flush;

  // The first cycle after reset only steps the PC to zero, so a flush there has nothing to cancel.
  assign flush = i_flush && (state != ST_BOOT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned (no latch).
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    skid_nxt       = skid_word;
    ifid_valid_nxt = o_ifid_valid;
    ifid_instr_nxt = o_ifid_instr;
    ifid_pc4_nxt   = o_ifid_pc4;
    pc_hold        = 1'b1;
    req            = 1'b0;

    if (flush) begin
      ifid_valid_nxt = 1'b0;
      ifid_instr_nxt = '0;
      pc_hold        = 1'b0;
    end

    case (state)
      ST_BOOT: begin
        pc_hold   = 1'b0;
        state_nxt = ST_REQ;
      end

      ST_REQ: begin
        if (!flush) begin
          req = 1'b1;
          if (i_imem_ready) begin
            fetch_pc_nxt = i_pc + 32'd4;
            state_nxt    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // The response still owed must be swallowed before a new request may go out.
          state_nxt = i_imem_valid ? ST_REQ : ST_DRAIN;
        end else if (i_imem_valid) begin
          if (i_stall) begin
            skid_nxt  = i_imem_rdata;
            state_nxt = ST_HOLD;
          end else begin
            ifid_valid_nxt = 1'b1;
            ifid_instr_nxt = i_imem_rdata;
            ifid_pc4_nxt   = fetch_pc;
            pc_hold        = 1'b0;
            state_nxt      = ST_REQ;
          end
        end
      end

      ST_DRAIN: begin
        if (i_imem_valid) state_nxt = ST_REQ;
      end

      ST_HOLD: begin
        if (flush) begin
          skid_nxt  = '0;
          state_nxt = ST_REQ;
        end else if (!i_stall) begin
          ifid_valid_nxt = 1'b1;
          ifid_instr_nxt = skid_word;
          ifid_pc4_nxt   = fetch_pc;
          pc_hold        = 1'b0;
          state_nxt      = ST_REQ;
        end
      end

      default: state_nxt = ST_BOOT;
    endcase
  end

  // Reset overrides everything combinationally as well, so the PC never moves while reset is held.
  assign o_pc_hold   = i_reset | pc_hold;
  assign o_imem_req  = ~i_reset & req;
  assign o_imem_addr = i_pc;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state        <= ST_BOOT;
      fetch_pc     <= '0;
      // NOTE: the skid word is a single register and is cleared so no stale word survives a reset.
      skid_word    <= '0;
      o_ifid_valid <= 1'b0;
      o_ifid_instr <= '0;
      o_ifid_pc4   <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      skid_word    <= skid_nxt;
      o_ifid_valid <= ifid_valid_nxt;
      o_ifid_instr <= ifid_instr_nxt;
      o_ifid_pc4   <= ifid_pc4_nxt;
    end
  end

endmodule
